// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) arbiter onto a single SRAM-like slave.
// One transaction outstanding at a time; data wins ties unless inst has starved.
module sram_like_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWNER_DATA = 1'b0, OWNER_INST = 1'b1} owner_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state, state_nxt;
  owner_t      owner;
  logic [2:0]  starve_cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        grant_inst, grant_data;

  // Arbitration is only live in IDLE and never while reset is asserted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE && !rst) begin
      grant_inst = inst_req && (!data_req || starve_cnt == STARVE_LIM);
      grant_data = data_req && !grant_inst;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_inst || grant_data) state_nxt = ADDR;
      ADDR:    if (s_addr_ok)                state_nxt = DATA;
      DATA:    if (s_data_ok)                state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWNER_DATA;
      starve_cnt <= 3'd0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else if (grant_inst) begin
      owner      <= OWNER_INST;
      starve_cnt <= 3'd0;
      wr_q       <= inst_wr;
      size_q     <= inst_size;
      addr_q     <= inst_addr;
      wdata_q    <= inst_wdata;
    end else if (grant_data) begin
      owner   <= OWNER_DATA;
      wr_q    <= data_wr;
      size_q  <= data_size;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
      // Count only data grants that actually made inst wait; saturate at the limit.
      if (inst_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    s_req        = (state == ADDR) && !rst;
    s_wr         = (state == ADDR) && !rst && wr_q;
    s_size       = size_q;
    s_addr       = addr_q;
    s_wdata      = wdata_q;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (state == DATA && !rst && s_data_ok) begin
      inst_data_ok = (owner == OWNER_INST);
      data_data_ok = (owner == OWNER_DATA);
    end
    inst_rdata = s_rdata;
    data_rdata = s_rdata;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change 1 ns after each rising edge,
// combinational outputs are checked 1 ns later, well before the next edge.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes an already-granted transaction with zero-wait slave acks.
  task automatic finish_txn();
    tick();
    s_addr_ok = 1'b1;
    tick();
    s_addr_ok = 1'b0;
    s_data_ok = 1'b1;
    tick();
    s_data_ok = 1'b0;
  endtask

  logic exp_inst_win [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    s_rdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;

    // Reset: outputs quiet even with a request pending.
    tick();
    tick();
    inst_req = 1'b1;
    #1;
    check_bit("rst_s_req", s_req, 1'b0);
    check_bit("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    check_bit("rst_data_data_ok", data_data_ok, 1'b0);
    check("rst_s_addr", s_addr, 32'h0);
    tick();
    rst = 1'b0;

    // Single inst read.
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2;
    #1;
    check_bit("t0_inst_addr_ok", inst_addr_ok, 1'b1);
    check_bit("t0_data_addr_ok", data_addr_ok, 1'b0);
    check_bit("t0_s_req", s_req, 1'b0);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b1;
    #1;
    check_bit("t1_s_req", s_req, 1'b1);
    check("t1_s_addr", s_addr, 32'h1FC0_0000);
    check_bit("t1_s_wr", s_wr, 1'b0);
    check_bit("t1_inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    s_addr_ok = 1'b0;
    #1;
    check_bit("t2_s_req", s_req, 1'b0);
    check_bit("t2_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h3C1D_0000;
    #1;
    check_bit("t3_inst_data_ok", inst_data_ok, 1'b1);
    check("t3_inst_rdata", inst_rdata, 32'h3C1D_0000);
    check_bit("t3_data_data_ok", data_data_ok, 1'b0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check("idle_s_size_held", {30'd0, s_size}, 32'd2);
    check_bit("idle_s_req", s_req, 1'b0);

    // Simultaneous requests: data wins, inst follows.
    inst_req = 1'b1; inst_addr = 32'h0000_0100; inst_wr = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_0200; data_wr = 1'b1;
    data_wdata = 32'hDEAD_BEEF; data_size = 2'd2;
    #1;
    check_bit("sim_data_addr_ok", data_addr_ok, 1'b1);
    check_bit("sim_inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    data_req = 1'b0; s_addr_ok = 1'b1;
    #1;
    check("sim_s_addr", s_addr, 32'h0000_0200);
    check_bit("sim_s_wr", s_wr, 1'b1);
    check("sim_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check_bit("sim_addr_ok_in_addr", inst_addr_ok, 1'b0);
    tick();
    s_addr_ok = 1'b0; s_data_ok = 1'b1;
    #1;
    check_bit("sim_data_data_ok", data_data_ok, 1'b1);
    check_bit("sim_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check_bit("sim_inst_grant_next", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b1;
    #1;
    check("sim_inst_s_addr", s_addr, 32'h0000_0100);
    tick();
    s_addr_ok = 1'b0; s_data_ok = 1'b1;
    #1;
    check_bit("sim_inst_data_ok2", inst_data_ok, 1'b1);
    tick();
    s_data_ok = 1'b0;

    // Starvation: both held high, expect data x4 then inst.
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    for (int g = 0; g < 5; g++) begin
      #1;
      check_bit($sformatf("starve_inst_win_%0d", g), inst_addr_ok, exp_inst_win[g]);
      check_bit($sformatf("starve_data_win_%0d", g), data_addr_ok, !exp_inst_win[g]);
      finish_txn();
    end
    inst_req = 1'b0; data_req = 1'b0;

    // Slave backpressure: s_addr_ok low 6 cycles, inst requesting meanwhile.
    data_req = 1'b1; data_addr = 32'hA5A5_0000;
    #1;
    check_bit("bp_grant", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0; inst_req = 1'b1; data_addr = 32'h0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_bit($sformatf("bp_s_req_%0d", c), s_req, 1'b1);
      check($sformatf("bp_s_addr_%0d", c), s_addr, 32'hA5A5_0000);
      check_bit($sformatf("bp_inst_addr_ok_%0d", c), inst_addr_ok, 1'b0);
      check_bit($sformatf("bp_data_addr_ok_%0d", c), data_addr_ok, 1'b0);
      tick();
    end
    inst_req = 1'b0; s_addr_ok = 1'b1;
    tick();
    s_addr_ok = 1'b0;

    // Reset while DATA waits for s_data_ok; a late ack must be dropped.
    #1;
    check_bit("md_s_req_data", s_req, 1'b0);
    rst = 1'b1;
    #1;
    check_bit("md_data_ok_in_rst", data_data_ok, 1'b0);
    tick();
    rst = 1'b0; s_data_ok = 1'b1;
    #1;
    check_bit("md_late_data_ok", data_data_ok, 1'b0);
    check_bit("md_late_inst_ok", inst_data_ok, 1'b0);
    check_bit("md_s_req", s_req, 1'b0);
    check("md_s_addr_cleared", s_addr, 32'h0);
    tick();
    s_data_ok = 1'b0;

    // Spurious acks in IDLE: no data_ok, state stays IDLE.
    s_data_ok = 1'b1; s_addr_ok = 1'b1;
    #1;
    check_bit("sp_inst_data_ok", inst_data_ok, 1'b0);
    check_bit("sp_data_data_ok", data_data_ok, 1'b0);
    tick();
    s_data_ok = 1'b0; s_addr_ok = 1'b0;
    #1;
    check_bit("sp_s_req", s_req, 1'b0);
    data_req = 1'b1;
    #1;
    check_bit("sp_still_idle_grant", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0;
    #1;
    check_bit("sp_addr_s_req", s_req, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
